mul_fp64: RTL and testbench
===========================

// Module: mul_fp64
// PURPOSE
//  Iterative IEEE-754 binary64 multiplier; the companion of div_fp64 in arithmetic-unit.
//  Uses the same valid_in/valid_out launch protocol, rm encoding and exception-flag set.
//  Radix-2 shift-add mantissa datapath trades latency for area. Fixed latency. No backpressure.
// PARAMETERS
//  LATENCY   56   cycles from accepting edge to the edge that raises valid_out (fixed, informative)
//  CNT_W     6    width of iteration counter (holds 0..52)
// PORTS
//  clock          in   1   single clock, all state updates on posedge
//  reset          in   1   synchronous, active-high
//  valid_in       in   1   launch request; sampled only in IDLE
//  rm             in   3   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
//  multiplicand   in   64  operand A, binary64
//  multiplier     in   64  operand B, binary64
//  valid_out      out  1   one-cycle pulse: product/flags valid
//  product        out  64  binary64 result; held until next valid_out
//  nv/of/uf/nx    out  1   invalid / overflow / underflow / inexact; held with product
// BEHAVIOUR
//  Reset: state=IDLE, valid_out=0, product=64'h0, all flags 0. Reset mid-operation aborts; no valid_out.
//  FSM: IDLE -> UNPACK -> MUL (53 cycles) -> NORM -> ROUND -> IDLE.
//   IDLE: valid_in=1 latches operands and rm, goes to UNPACK. valid_in in any other state is ignored/dropped.
//   UNPACK: classify zero/sub/norm/inf/qNaN/sNaN; build 53-bit mantissas (implicit 1); sign = sa^sb;
//    exp = ea+eb-1023 (13-bit signed; subnormal exp taken as 1).
//   MUL: 106-bit accumulator, 1 multiplier bit per cycle, counter 0..52.
//   NORM: if acc[105], shift right 1 and exp+1; else leading-zero normalise (subnormal inputs).
//    If exp<1, right-shift by (1-exp) into the subnormal range; all shifted-out bits OR'd into sticky.
//   ROUND: apply guard/round/sticky per rm, handle mantissa carry-out (exp+1), register product and flags.
//   ROUND also pulses valid_out.
//  Latency: accept at edge E -> valid_out high for the cycle after edge E+56. Specials take the same path.
//   Back-to-back: FSM is IDLE during the valid_out cycle, so valid_in asserted in that cycle is accepted.
//  Specials (override datapath result at ROUND):
//   any NaN -> canonical qNaN 64'h7FF8000000000000; nv=1 iff any sNaN.
//   inf*0 -> canonical qNaN, nv=1. inf*finite-nonzero -> signed inf, no flags.
//   zero*finite -> signed zero, no flags.
//  Overflow (rounded exp >= 2047): of=1, nx=1.
//   RNE/RMM -> signed inf. RTZ -> signed max finite (7FEF_FFFF_FFFF_FFFF).
//   RDN -> +max finite or -inf. RUP -> +inf or -max finite.
//  Underflow: tininess detected after rounding; uf=1 only if tiny AND inexact. nx=1 whenever any discarded bit != 0.
//  dz never applies (port omitted).
// CONFIGURATION
//  MUL_FP64_SUBNORM_EN defined: full gradual underflow (subnormal inputs and outputs as above).
//  Not defined: flush-to-zero.
//   Subnormal inputs are treated as signed zero (no flag).
//   Results with exp<1 after rounding become signed zero with uf=1, nx=1.
//   The NORM leading-zero shifter is removed.
// TESTING
//  1. 3FF8000000000000 (1.5) x 4000000000000000 (2.0), rm=000 -> 4008000000000000, flags 0.
//     valid_out exactly 56 cycles after accept.
//  2. 7FF0000000000000 x 0000000000000000 -> 7FF8000000000000, nv=1.
//     7FF4000000000000 (sNaN) x 3FF0000000000000 -> 7FF8000000000000, nv=1.
//  3. 7FEFFFFFFFFFFFFF x 4000000000000000: rm=001 -> 7FEFFFFFFFFFFFFF; rm=000 -> 7FF0000000000000.
//     of=1, nx=1 in both cases.
//  4. 3FF0000000000001 x 3FF0000000000001: rm=000 -> 3FF0000000000002, nx=1.
//     rm=011 -> 3FF0000000000003, nx=1.
//  5. 0010000000000000 x 3FE0000000000000:
//     with _EN -> 0008000000000000, flags 0; without -> 0000000000000000, uf=1, nx=1.
//  6. valid_in held high during busy cycles -> no extra results.
//     Reset at cycle 20 of an operation -> no valid_out, outputs 0. Next launch completes normally.

Source files
------------

// File: rtl/mul_fp64_if.sv
// mul_fp64_if: launch/result bundle for the iterative binary64 multiplier.
// master drives operands and valid_in; slave returns the registered product and flags.
interface mul_fp64_if;
  logic        valid_in;
  logic [2:0]  rm;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        valid_out;
  logic [63:0] product;
  logic        nv;
  logic        of;
  logic        uf;
  logic        nx;

  modport master (
    output valid_in, rm, multiplicand, multiplier,
    input  valid_out, product, nv, of, uf, nx
  );

  modport slave (
    input  valid_in, rm, multiplicand, multiplier,
    output valid_out, product, nv, of, uf, nx
  );
endinterface

// File: rtl/mul_fp64.sv
// mul_fp64: iterative radix-2 shift-add IEEE-754 binary64 multiplier, fixed 56-cycle latency.
// Define MUL_FP64_SUBNORM_EN for gradual underflow; otherwise subnormals flush to zero.
module mul_fp64 #(
  parameter int unsigned LATENCY = 56,
  parameter int unsigned CNT_W   = 6
) (
  input logic       clock,
  input logic       reset,
  mul_fp64_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 4);
  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [62:0] MAX_FIN = 63'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [62:0] INF     = {11'h7FF, 52'h0};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND} state_t;
  state_t state;

  logic [63:0]        a_q, b_q, spec_res_q;
  logic [2:0]         rm_q;
  logic               sign_q, spec_q, spec_nv_q, st_q, tiny_q;
  logic signed [12:0] exp_q;
  logic [52:0]        ma_q, mb_q;
  logic [105:0]       acc_q;
  logic [CNT_W-1:0]   cnt_q;

  function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                     input logic lsb, input logic g, input logic s);
    case (mode)
      3'b001:  round_inc = 1'b0;
      3'b010:  round_inc = sgn & (g | s);
      3'b011:  round_inc = ~sgn & (g | s);
      3'b100:  round_inc = g;
      default: round_inc = g & (s | lsb);
    endcase
  endfunction

  // Operand classification and specials
  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic u_sign, u_spec, u_nv;
  logic [63:0] u_res;
  logic signed [12:0] u_exp;

  always_comb begin
    ea = a_q[62:52];
    eb = b_q[62:52];
    fa = a_q[51:0];
    fb = b_q[51:0];
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    a_snan = a_nan && !fa[51];
    b_snan = b_nan && !fb[51];
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
`ifdef MUL_FP64_SUBNORM_EN
    a_zero = (ea == '0) && (fa == '0);
    b_zero = (eb == '0) && (fb == '0);
`else
    a_zero = (ea == '0);
    b_zero = (eb == '0);
`endif
    u_sign = a_q[63] ^ b_q[63];
    u_exp  = $signed({2'b00, (ea == '0) ? 11'd1 : ea}) +
             $signed({2'b00, (eb == '0) ? 11'd1 : eb}) - 13'sd1023;
    u_spec = 1'b1;
    u_nv   = 1'b0;
    u_res  = {u_sign, 63'h0};
    if (a_nan || b_nan) begin
      u_res = QNAN;
      u_nv  = a_snan | b_snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      u_res = QNAN;
      u_nv  = 1'b1;
    end else if (a_inf || b_inf) begin
      u_res = {u_sign, INF};
    end else if (!(a_zero || b_zero)) begin
      u_spec = 1'b0;
    end
  end

  // Right-shifting accumulator: upper half takes the partial sum, low half collects product bits
  logic [53:0] mul_sum;
  always_comb mul_sum = {1'b0, acc_q[105:53]} + (mb_q[0] ? {1'b0, ma_q} : 54'd0);

  // Normalisation, tininess (judged on the unbounded 53-bit rounding) and denormalisation
  logic [104:0]       n1, n2;
  logic               s1, s2, carry_n, tiny;
  logic signed [12:0] e1, e2;
`ifdef MUL_FP64_SUBNORM_EN
  logic [6:0]         lz, shc;
  logic signed [12:0] sh;
`endif

  always_comb begin
    if (acc_q[105]) begin
      n1 = acc_q[105:1];
      s1 = acc_q[0];
      e1 = exp_q + 13'sd1;
    end else begin
      n1 = acc_q[104:0];
      s1 = 1'b0;
      e1 = exp_q;
    end
`ifdef MUL_FP64_SUBNORM_EN
    lz = '0;
    for (int unsigned i = 0; i < 105; i++)
      if (acc_q[i]) lz = 7'(104 - i);
    if (!acc_q[105]) begin
      n1 = acc_q[104:0] << lz;
      e1 = exp_q - $signed({6'b0, lz});
    end
`endif
    carry_n = (&n1[104:52]) & round_inc(rm_q, sign_q, n1[52], n1[51], (|n1[50:0]) | s1);
    tiny    = (e1 < 13'sd1) && !((e1 == 13'sd0) && carry_n);
    n2 = n1;
    s2 = s1;
    e2 = e1;
`ifdef MUL_FP64_SUBNORM_EN
    sh  = 13'sd1 - e1;
    shc = '0;
    if (e1 < 13'sd1) begin
      shc = (sh > 13'sd105) ? 7'd105 : sh[6:0];
      n2  = n1 >> shc;
      s2  = s1 | (|(n1 & ~({105{1'b1}} << shc)));
      e2  = 13'sd1;
    end
`endif
  end

  // Rounding and result packing
  logic [52:0]        r_mant, r_frac;
  logic [53:0]        r_sum;
  logic               r_g, r_s, r_inx, r_of, r_uf, r_nx;
  logic signed [12:0] r_exp;
  logic [63:0]        r_res;

  always_comb begin
    r_mant = acc_q[104:52];
    r_g    = acc_q[51];
    r_s    = (|acc_q[50:0]) | st_q;
    r_inx  = r_g | r_s;
    r_sum  = {1'b0, r_mant} + 54'(round_inc(rm_q, sign_q, r_mant[0], r_g, r_s));
    if (r_sum[53]) begin
      r_frac = r_sum[53:1];
      r_exp  = exp_q + 13'sd1;
    end else begin
      r_frac = r_sum[52:0];
      r_exp  = exp_q;
    end
    r_res = {sign_q, (r_frac[52] ? r_exp[10:0] : 11'd0), r_frac[51:0]};
    r_of  = 1'b0;
    r_uf  = 1'b0;
    r_nx  = r_inx;
    if (r_exp >= 13'sd2047) begin
      r_of = 1'b1;
      r_nx = 1'b1;
      case (rm_q)
        3'b001:  r_res = {sign_q, MAX_FIN};
        3'b010:  r_res = {sign_q, sign_q ? INF : MAX_FIN};
        3'b011:  r_res = {sign_q, sign_q ? MAX_FIN : INF};
        default: r_res = {sign_q, INF};
      endcase
    end
`ifdef MUL_FP64_SUBNORM_EN
    else r_uf = tiny_q & r_inx;
`else
    else if (tiny_q) begin
      r_res = {sign_q, 63'h0};
      r_uf  = 1'b1;
      r_nx  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.valid_out <= 1'b0;
      bus.product   <= '0;
      bus.nv        <= 1'b0;
      bus.of        <= 1'b0;
      bus.uf        <= 1'b0;
      bus.nx        <= 1'b0;
    end else begin
      bus.valid_out <= 1'b0;
      case (state)
        S_IDLE: if (bus.valid_in) begin
          a_q   <= bus.multiplicand;
          b_q   <= bus.multiplier;
          rm_q  <= bus.rm;
          state <= S_UNPACK;
        end
        S_UNPACK: begin
          sign_q     <= u_sign;
          exp_q      <= u_exp;
          ma_q       <= {ea != '0, fa};
          mb_q       <= {eb != '0, fb};
          spec_q     <= u_spec;
          spec_nv_q  <= u_nv;
          spec_res_q <= u_res;
          acc_q      <= '0;
          cnt_q      <= '0;
          state      <= S_MUL;
        end
        S_MUL: begin
          acc_q <= {mul_sum, acc_q[52:1]};
          mb_q  <= mb_q >> 1;
          if (cnt_q == CNT_LAST) state <= S_NORM;
          else cnt_q <= cnt_q + CNT_W'(1);
        end
        S_NORM: begin
          acc_q  <= {1'b0, n2};
          st_q   <= s2;
          exp_q  <= e2;
          tiny_q <= tiny;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          bus.valid_out <= 1'b1;
          if (spec_q) begin
            bus.product <= spec_res_q;
            bus.nv      <= spec_nv_q;
            bus.of      <= 1'b0;
            bus.uf      <= 1'b0;
            bus.nx      <= 1'b0;
          end else begin
            bus.product <= r_res;
            bus.nv      <= 1'b0;
            bus.of      <= r_of;
            bus.uf      <= r_uf;
            bus.nx      <= r_nx;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_fp64.sv
// tb_mul_fp64: directed and random checks of mul_fp64 against an exact-integer reference model.
// Honours MUL_FP64_SUBNORM_EN the same way the design does.
module tb_mul_fp64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  mul_fp64_if bus();

  mul_fp64 #(.LATENCY(56), .CNT_W(6)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] p;
    logic [3:0]  f;   // {nv, of, uf, nx}
  } res_t;

  int vectors = 0;
  int miscompares = 0;
  int n_cmp = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  // Round integer p at bit q (bits below q discarded) in mode rm for sign s
  function automatic void round_at(input logic [127:0] p, input int q_in, input logic [2:0] rm,
                                   input logic s, output logic [127:0] kept, output logic inexact);
    logic [127:0] rem, half;
    logic up;
    int q;
    q = (q_in > 110) ? 110 : q_in;
    if (q <= 0) begin
      kept = p << (-q);
      inexact = 1'b0;
    end else begin
      kept = p >> q;
      rem  = p - (kept << q);
      half = 128'd1 << (q - 1);
      inexact = (rem != 0);
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = s & inexact;
        3'd3:    up = !s & inexact;
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || ((rem == half) && kept[0]);
      endcase
      kept = kept + {127'd0, up};
    end
  endfunction

  function automatic res_t ref_mul(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm);
    res_t r;
    logic s, na, nb, sa, sb, ia, ib, za, zb, inx, inx_n, tiny;
    logic [127:0] p, k, kn;
    int ex_a, ex_b, e, msb, q, be;
    r  = '0;
    s  = a[63] ^ b[63];
    na = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    nb = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    sa = na && !a[51];
    sb = nb && !b[51];
    ia = (a[62:0] == {11'h7FF, 52'd0});
    ib = (b[62:0] == {11'h7FF, 52'd0});
`ifdef MUL_FP64_SUBNORM_EN
    za = (a[62:0] == 0);
    zb = (b[62:0] == 0);
`else
    za = (a[62:52] == 0);
    zb = (b[62:52] == 0);
`endif
    if (na || nb) begin
      r.p = 64'h7FF8_0000_0000_0000;
      r.f = {sa | sb, 3'b000};
    end else if ((ia && zb) || (ib && za)) begin
      r.p = 64'h7FF8_0000_0000_0000;
      r.f = 4'b1000;
    end else if (ia || ib) begin
      r.p = {s, 11'h7FF, 52'd0};
    end else if (za || zb) begin
      r.p = {s, 63'd0};
    end else begin
      // value = p * 2^e exactly
      ex_a = (a[62:52] == 0) ? 1 : int'(a[62:52]);
      ex_b = (b[62:52] == 0) ? 1 : int'(b[62:52]);
      p = {75'd0, (a[62:52] != 0), a[51:0]} * {75'd0, (b[62:52] != 0), b[51:0]};
      e = ex_a + ex_b - 2150;
      msb = 0;
      for (int i = 0; i < 128; i++) if (p[i]) msb = i;
      round_at(p, msb - 52, rm, s, kn, inx_n);
      tiny = (msb + e + 1023 + (kn[53] ? 1 : 0)) < 1;
`ifdef MUL_FP64_SUBNORM_EN
      q = (msb - 52 > -1074 - e) ? msb - 52 : -1074 - e;
`else
      q = msb - 52;
`endif
      round_at(p, q, rm, s, k, inx);
      if (k[53]) begin
        k = k >> 1;
        q = q + 1;
      end
      be = q + e + 1075;
      if (k[52] && be >= 2047) begin
        r.f = 4'b0101;
        case (rm)
          3'd1:    r.p = {s, 63'h7FEF_FFFF_FFFF_FFFF};
          3'd2:    r.p = s ? 64'hFFF0_0000_0000_0000 : 64'h7FEF_FFFF_FFFF_FFFF;
          3'd3:    r.p = s ? 64'hFFEF_FFFF_FFFF_FFFF : 64'h7FF0_0000_0000_0000;
          default: r.p = {s, 11'h7FF, 52'd0};
        endcase
      end else begin
`ifdef MUL_FP64_SUBNORM_EN
        r.p = k[52] ? {s, be[10:0], k[51:0]} : {s, 11'd0, k[51:0]};
        r.f = {2'b00, tiny & inx, inx};
`else
        if (tiny) begin
          r.p = {s, 63'd0};
          r.f = 4'b0011;
        end else begin
          r.p = {s, be[10:0], k[51:0]};
          r.f = {3'b000, inx};
        end
`endif
      end
    end
    return r;
  endfunction

  function automatic res_t mk(input logic [63:0] p, input logic [3:0] f);
    res_t r;
    r.p = p;
    r.f = f;
    return r;
  endfunction

  // Called at #1 after an edge with the DUT idle; returns #1 after the edge that raised valid_out
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] rm, input res_t expv);
    int cyc;
    bus.valid_in = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    bus.rm = rm;
    @(posedge clock); #1;
    bus.valid_in = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier = ~b;
    bus.rm = ~rm;
    cyc = 0;
    while (bus.valid_out !== 1'b1 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    vectors++;
    chk({tag, " latency"}, 64'(cyc), 64'd56);
    chk({tag, " product"}, bus.product, expv.p);
    chk({tag, " flags nv/of/uf/nx"}, {60'd0, bus.nv, bus.of, bus.uf, bus.nx}, {60'd0, expv.f});
  endtask

  task automatic count_pulses(input int ncyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock); #1;
      if (bus.valid_out === 1'b1) pulses++;
    end
  endtask

  function automatic logic [63:0] rand_fp();
    logic [63:0] w;
    logic [51:0] f;
    logic [10:0] e;
    w = {$urandom, $urandom};
    f = w[51:0];
    case ($urandom_range(0, 15))
      0: begin e = 11'd0; f = '0; end
      1: begin e = 11'h7FF; f = '0; end
      2: begin e = 11'h7FF; if (f == 0) f = 52'd1; end
      3: begin e = 11'd0; if (f == 0) f = 52'd1; end
      4: e = 11'(2047 - $urandom_range(1, 200));
      5: e = 11'($urandom_range(1, 200));
      6: begin e = 11'($urandom_range(900, 1100)); f = '1; end
      default: e = 11'($urandom_range(1, 2046));
    endcase
    return {w[63], e, f};
  endfunction

  initial begin
    int pulses, cyc;
    logic [63:0] a, b;
    logic [2:0] rm;
    bus.valid_in = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.rm = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset valid_out", {63'd0, bus.valid_out}, 64'd0);
    chk("reset product", bus.product, 64'd0);
    chk("reset flags", {60'd0, bus.nv, bus.of, bus.uf, bus.nx}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("t1 1.5x2", 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0,
           mk(64'h4008_0000_0000_0000, 4'b0000));
    @(posedge clock); #1;
    chk("t1 pulse width", {63'd0, bus.valid_out}, 64'd0);
    chk("t1 product held", bus.product, 64'h4008_0000_0000_0000);

    // consecutive calls launch in the valid_out cycle, exercising back-to-back acceptance
    run_op("t2 inf*0", 64'h7FF0_0000_0000_0000, 64'h0, 3'd0, mk(64'h7FF8_0000_0000_0000, 4'b1000));
    run_op("t2 snan", 64'h7FF4_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'd0,
           mk(64'h7FF8_0000_0000_0000, 4'b1000));
    run_op("t3 ovf rtz", 64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 3'd1,
           mk(64'h7FEF_FFFF_FFFF_FFFF, 4'b0101));
    run_op("t3 ovf rne", 64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 3'd0,
           mk(64'h7FF0_0000_0000_0000, 4'b0101));
    run_op("t4 rne", 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 3'd0,
           mk(64'h3FF0_0000_0000_0002, 4'b0001));
    run_op("t4 rup", 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 3'd3,
           mk(64'h3FF0_0000_0000_0003, 4'b0001));
`ifdef MUL_FP64_SUBNORM_EN
    run_op("t5 subnorm", 64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 3'd0,
           mk(64'h0008_0000_0000_0000, 4'b0000));
`else
    run_op("t5 ftz", 64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 3'd0,
           mk(64'h0000_0000_0000_0000, 4'b0011));
`endif
    run_op("inf*neg", 64'h7FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 3'd0,
           mk(64'hFFF0_0000_0000_0000, 4'b0000));
    @(posedge clock); #1;

    // valid_in held high while busy, with operands changing underneath
    bus.valid_in = 1'b1;
    bus.multiplicand = 64'h3FF8_0000_0000_0000;
    bus.multiplier = 64'h4000_0000_0000_0000;
    bus.rm = 3'd0;
    @(posedge clock); #1;
    cyc = 0;
    while (bus.valid_out !== 1'b1 && cyc < 200) begin
      if (cyc == 10) bus.multiplicand = 64'h4010_0000_0000_0000;
      @(posedge clock); #1;
      cyc++;
    end
    bus.valid_in = 1'b0;
    vectors++;
    chk("t6 held latency", 64'(cyc), 64'd56);
    chk("t6 held product", bus.product, 64'h4008_0000_0000_0000);
    count_pulses(70, pulses);
    chk("t6 held extra results", 64'(pulses), 64'd0);

    // reset at cycle 20 of an operation
    bus.valid_in = 1'b1;
    bus.multiplicand = 64'h4000_0000_0000_0000;
    bus.multiplier = 64'h4000_0000_0000_0000;
    @(posedge clock); #1;
    bus.valid_in = 1'b0;
    repeat (19) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t6 abort product", bus.product, 64'd0);
    chk("t6 abort flags", {59'd0, bus.valid_out, bus.nv, bus.of, bus.uf, bus.nx}, 64'd0);
    count_pulses(70, pulses);
    chk("t6 abort no result", 64'(pulses), 64'd0);
    run_op("t6 after abort", 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0,
           mk(64'h4008_0000_0000_0000, 4'b0000));

    for (int i = 0; i < 120; i++) begin
      a  = rand_fp();
      b  = rand_fp();
      rm = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d %h*%h rm%0d", i, a, b, rm), a, b, rm, ref_mul(a, b, rm));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
